// File: rtl/irq_arbiter_pkg.sv
// Shared definitions for the interrupt request arbiter.
//   INT_PRIO_W       width of the priority presented to intc
//   INT_VEC_W        width of the interrupt vector presented to intc
//   VEC_BASE_DEFAULT vector of source 0 unless overridden
//   irq_state_t      presentation FSM state encoding
package irq_arbiter_pkg;

   localparam int INT_PRIO_W = 3;
   localparam int INT_VEC_W  = 8;
   localparam logic [INT_VEC_W-1:0] VEC_BASE_DEFAULT = 8'h80;

   typedef enum logic [1:0] {
      IRQ_IDLE    = 2'd0,
      IRQ_PRESENT = 2'd1,
      IRQ_ACKED   = 2'd2
   } irq_state_t;

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchronizer plus rising-edge detector for one raw request line.
// Ports:
//   clk    in   system clock
//   rst_n  in   async active-low reset
//   req    in   raw asynchronous request level
//   rise   out  one-cycle pulse: a synchronized low->high transition was seen
module irq_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic req,
   output logic rise
);

   logic sync1;
   logic sync2;
   logic prev;
   logic fill1;
   logic fill2;
   logic armed;

   // fill1/fill2 track when sync2 holds a real sample rather than its reset
   // value. A rise is only accepted once a genuine low has been observed, so
   // a request that is still high when reset is released is not mistaken
   // for a new one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
         fill1 <= 1'b0;
         fill2 <= 1'b0;
         armed <= 1'b0;
      end else begin
         sync1 <= req;
         sync2 <= sync1;
         prev  <= sync2;
         fill1 <= 1'b1;
         fill2 <= fill1;
         if (fill2 && !sync2) begin
            armed <= 1'b1;
         end
      end
   end

   assign rise = armed & sync2 & ~prev;

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt request arbiter: latches device requests as pending, selects the
// highest-priority enabled pending source and presents it to intc until the
// control FSM acknowledges it.
// Ports:
//   clk           in   system clock
//   rst_n         in   async active-low reset
//   irq_req       in   raw device requests (rising edge = new request)
//   ld_ie         in   load enable mask from bus[NUM_SRC-1:0]
//   bus           in   16-bit datapath bus
//   int_ack       in   one-cycle pulse: presented interrupt has been taken
//   int_priority  out  priority of presented source, 0 = none
//   int_vec       out  vector of presented source
//   irq_pending   out  pending bits
//   irq_ie        out  enable mask
module irq_arbiter
   import irq_arbiter_pkg::*;
#(
   parameter int                      NUM_SRC  = 4,
   parameter logic [3*NUM_SRC-1:0]    SRC_PRIO = 12'b100_100_100_100,
   parameter logic [INT_VEC_W-1:0]    VEC_BASE = VEC_BASE_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_SRC-1:0]    irq_req,
   input  logic                  ld_ie,
   input  logic [15:0]           bus,
   input  logic                  int_ack,
   output logic [INT_PRIO_W-1:0] int_priority,
   output logic [INT_VEC_W-1:0]  int_vec,
   output logic [NUM_SRC-1:0]    irq_pending,
   output logic [NUM_SRC-1:0]    irq_ie
);

   localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   irq_state_t state_q;
   irq_state_t state_d;

   logic [NUM_SRC-1:0]    rise;
   logic [NUM_SRC-1:0]    elig;
   logic [NUM_SRC-1:0]    clr_mask;
   logic [IDX_W-1:0]      sel_idx;
   logic [IDX_W-1:0]      sel_d;
   logic [INT_PRIO_W-1:0] prio_d;
   logic [INT_VEC_W-1:0]  vec_d;
   logic                  clr;
   logic                  sel_live;

   logic                  cand_found;
   logic [INT_PRIO_W-1:0] cand_prio;
   logic [IDX_W-1:0]      cand_idx;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
      irq_sync_edge u_sync (
         .clk   (clk),
         .rst_n (rst_n),
         .req   (irq_req[g]),
         .rise  (rise[g])
      );
   end

   assign elig     = irq_pending & irq_ie;
   assign sel_live = elig[sel_idx];

   // Strict '>' keeps the lowest index among equal maxima, and a source whose
   // priority is 0 can never beat the initial value, so it never presents.
   always_comb begin
      cand_found = 1'b0;
      cand_prio  = '0;
      cand_idx   = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (elig[i] && (SRC_PRIO[3*i +: 3] > cand_prio)) begin
            cand_found = 1'b1;
            cand_prio  = SRC_PRIO[3*i +: 3];
            cand_idx   = IDX_W'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IRQ_IDLE;
         int_priority <= '0;
         int_vec      <= '0;
         sel_idx      <= '0;
      end else begin
         state_q      <= state_d;
         int_priority <= prio_d;
         int_vec      <= vec_d;
         sel_idx      <= sel_d;
      end
   end

   // While PRESENT, int_priority holds the presented source's priority, so it
   // doubles as the reference for preemption. An ack takes precedence over a
   // preempt in the same cycle: the control FSM has already taken the vector.
   always_comb begin
      state_d = state_q;
      prio_d  = int_priority;
      vec_d   = int_vec;
      sel_d   = sel_idx;
      clr     = 1'b0;
      case (state_q)
         IRQ_IDLE: begin
            prio_d = '0;
            vec_d  = '0;
            if (cand_found) begin
               state_d = IRQ_PRESENT;
               prio_d  = cand_prio;
               vec_d   = VEC_BASE + INT_VEC_W'(cand_idx);
               sel_d   = cand_idx;
            end
         end
         IRQ_PRESENT: begin
            if (int_ack) begin
               state_d = IRQ_ACKED;
               prio_d  = '0;
               vec_d   = '0;
               clr     = 1'b1;
            end else if (!sel_live) begin
               state_d = IRQ_IDLE;
               prio_d  = '0;
               vec_d   = '0;
            end else if (cand_prio > int_priority) begin
               prio_d = cand_prio;
               vec_d  = VEC_BASE + INT_VEC_W'(cand_idx);
               sel_d  = cand_idx;
            end
         end
         IRQ_ACKED: begin
            state_d = IRQ_IDLE;
            prio_d  = '0;
            vec_d   = '0;
         end
         default: begin
            state_d = IRQ_IDLE;
            prio_d  = '0;
            vec_d   = '0;
         end
      endcase
   end

   always_comb begin
      clr_mask = '0;
      if (clr) begin
         clr_mask[sel_idx] = 1'b1;
      end
   end

   // A new edge on the source being acknowledged wins over the clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_pending <= '0;
         irq_ie      <= '0;
      end else begin
         irq_pending <= rise | (irq_pending & ~clr_mask);
         if (ld_ie) begin
            irq_ie <= bus[NUM_SRC-1:0];
         end
      end
   end

endmodule

// File: tb/tb_irq_arbiter.sv
module tb_irq_arbiter;

   localparam int NUM_SRC = 4;
   localparam int EXP_W   = 19;

   // Source priorities {src3, src2, src1, src0} = {1, 5, 5, 2}
   localparam logic [11:0] DUT_PRIO = 12'b001_101_101_010;
   int prio_tab[NUM_SRC] = '{2, 5, 5, 1};

   logic        clk;
   logic        rst_n;
   logic [3:0]  irq_req;
   logic        ld_ie;
   logic [15:0] bus;
   logic        int_ack;
   logic [2:0]  int_priority;
   logic [7:0]  int_vec;
   logic [3:0]  irq_pending;
   logic [3:0]  irq_ie;

   irq_arbiter #(
      .NUM_SRC  (NUM_SRC),
      .SRC_PRIO (DUT_PRIO),
      .VEC_BASE (8'h80)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .irq_req      (irq_req),
      .ld_ie        (ld_ie),
      .bus          (bus),
      .int_ack      (int_ack),
      .int_priority (int_priority),
      .int_vec      (int_vec),
      .irq_pending  (irq_pending),
      .irq_ie       (irq_ie)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   logic [EXP_W-1:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Model of observable behaviour: requests are sampled at every clock edge
   // since reset; a new request is recognised when the sample taken two edges
   // back is high and the one before it low, which gives the 3-clock
   // request-to-pending latency and ignores a level already high at reset.
   logic [3:0] req_hist[$];
   int         m_mode;   // 0 idle, 1 presenting, 2 one-clock acked gap
   int         m_pres;
   logic [2:0] m_prio;
   logic [7:0] m_vec;
   logic [3:0] m_pend;
   logic [3:0] m_ie;
   logic       rst_val;
   logic [3:0] cur_req;

   task automatic model_reset();
      m_mode = 0;
      m_pres = 0;
      m_prio = '0;
      m_vec  = '0;
      m_pend = '0;
      m_ie   = '0;
      req_hist.delete();
   endtask

   task automatic model_edge();
      logic [3:0] new_req;
      int n, cand, cprio, clr;
      if (!rst_n) begin
         model_reset();
         return;
      end
      req_hist.push_back(irq_req);
      n = req_hist.size() - 1;
      new_req = '0;
      if (n >= 3) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            new_req[i] = req_hist[n-2][i] & ~req_hist[n-3][i];
         end
      end
      cand  = -1;
      cprio = 0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (m_pend[i] && m_ie[i] && prio_tab[i] > cprio) begin
            cand  = i;
            cprio = prio_tab[i];
         end
      end
      clr = -1;
      case (m_mode)
         0: begin
            if (cand >= 0) begin
               m_mode = 1;
               m_pres = cand;
               m_prio = 3'(cprio);
               m_vec  = 8'(8'h80 + cand);
            end
         end
         1: begin
            if (int_ack) begin
               clr = m_pres;
               m_mode = 2;
               m_prio = '0;
               m_vec  = '0;
            end else if (!(m_pend[m_pres] && m_ie[m_pres])) begin
               m_mode = 0;
               m_prio = '0;
               m_vec  = '0;
            end else if (cprio > prio_tab[m_pres]) begin
               m_pres = cand;
               m_prio = 3'(cprio);
               m_vec  = 8'(8'h80 + cand);
            end
         end
         default: begin
            m_mode = 0;
            m_prio = '0;
            m_vec  = '0;
         end
      endcase
      for (int i = 0; i < NUM_SRC; i++) begin
         m_pend[i] = new_req[i] | (m_pend[i] & (i != clr));
      end
      if (ld_ie) m_ie = bus[3:0];
   endtask

   // ---------------- driver ----------------
   // One call = one clock edge: inputs change just after the falling edge,
   // the model predicts the state after the next rising edge, and the
   // monitor compares at the falling edge that follows it.
   task automatic cycle(input logic ld, input logic [15:0] b, input logic ack);
      @(negedge clk);
      #1;
      rst_n   = rst_val;
      irq_req = cur_req;
      ld_ie   = ld;
      bus     = b;
      int_ack = ack;
      model_edge();
      exp_q.push_back({m_prio, m_vec, m_pend, m_ie});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 1'b0);
   endtask

   task automatic ack_when_present(input string name);
      bit done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         if (m_mode == 1) begin
            cycle(1'b0, 16'h0, 1'b1);
            done = 1;
         end else begin
            idle(1);
         end
      end
      n_checks++;
      if (!done) begin
         n_fail++;
         $display("FAIL %s: no presentation within 20 cycles, expected one", name);
      end
   endtask

   // Asserts reset asynchronously between edges and checks the outputs
   // clear immediately, before any clock edge.
   task automatic async_reset(input int hold);
      @(negedge clk);
      #2;
      rst_val = 1'b0;
      rst_n   = 1'b0;
      #1;
      check("async_rst_prio", 16'(int_priority), 16'h0);
      check("async_rst_vec",  16'(int_vec),      16'h0);
      check("async_rst_pend", 16'(irq_pending),  16'h0);
      check("async_rst_ie",   16'(irq_ie),       16'h0);
      model_reset();
      idle(hold);
      rst_val = 1'b1;
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [EXP_W-1:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("int_priority", 16'(int_priority), 16'(e[18:16]));
         check("int_vec",      16'(int_vec),      16'(e[15:8]));
         check("irq_pending",  16'(irq_pending),  16'(e[7:4]));
         check("irq_ie",       16'(irq_ie),       16'(e[3:0]));
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      rst_val = 1'b0;
      rst_n   = 1'b0;
      cur_req = '0;
      irq_req = '0;
      ld_ie   = 1'b0;
      bus     = '0;
      int_ack = 1'b0;
      model_reset();
      #1;
      check("reset_prio", 16'(int_priority), 16'h0);
      check("reset_pend", 16'(irq_pending),  16'h0);
      idle(3);
      rst_val = 1'b1;
      idle(4);

      // Single source: src0 only enabled
      cycle(1'b1, 16'h0001, 1'b0);
      cur_req = 4'b0001;
      idle(5);
      ack_when_present("single");
      idle(3);
      cur_req = 4'b0000;
      idle(3);

      // Tie and priority ordering with all sources enabled
      cycle(1'b1, 16'h000F, 1'b0);
      cur_req = 4'b1111;
      idle(5);
      for (int k = 0; k < 4; k++) ack_when_present("tie_order");
      idle(3);
      cur_req = 4'b0000;
      idle(3);

      // Preempt: src0 presented, then src1 raised before the ack
      cur_req = 4'b0001;
      idle(5);
      cur_req = 4'b0011;
      idle(5);
      ack_when_present("preempt");
      ack_when_present("preempt");
      idle(2);
      cur_req = 4'b0000;
      idle(3);

      // Mask the presented source, then re-enable it
      cur_req = 4'b0001;
      idle(5);
      cycle(1'b1, 16'h0000, 1'b0);
      idle(3);
      cycle(1'b1, 16'h0001, 1'b0);
      idle(3);

      // Collision: fresh edge on src0 arrives in the same edge as its ack
      cur_req = 4'b0000;
      idle(3);
      cur_req = 4'b0001;
      cycle(1'b0, 16'h0, 1'b0);
      cycle(1'b0, 16'h0, 1'b0);
      cycle(1'b0, 16'h0, 1'b1);
      idle(4);
      ack_when_present("collision");
      idle(2);

      // Reset mid-presentation with the request held high: not re-detected
      cur_req = 4'b0000;
      idle(3);
      cur_req = 4'b0001;
      idle(5);
      async_reset(2);
      cycle(1'b1, 16'h000F, 1'b0);
      idle(8);
      cur_req = 4'b0000;
      idle(3);
      cur_req = 4'b0001;
      idle(6);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         logic [3:0] flips;
         for (int b = 0; b < NUM_SRC; b++) flips[b] = ($urandom_range(0, 7) == 0);
         cur_req = cur_req ^ flips;
         if ($urandom_range(0, 499) == 0) begin
            async_reset($urandom_range(1, 3));
         end else if ($urandom_range(0, 15) == 0) begin
            cycle(1'b1, 16'($urandom), 1'b0);
         end else if (m_mode == 1) begin
            cycle(1'b0, 16'h0, 1'($urandom_range(0, 1)));
         end else begin
            cycle(1'b0, 16'h0, ($urandom_range(0, 15) == 0));
         end
      end

      @(negedge clk);
      @(negedge clk);
      check("queue_drained", 16'(exp_q.size()), 16'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
